fetch_redirect_unit: RTL and testbench

Owns the fetch PC register. Predicts next-fetch PC with a small direct-mapped branch target buffer (BTB) and 2-bit counters. Consumes the ID-stage branch/jump resolution (target, taken, jump flags), corrects mispredictions by redirecting PC and flushing IF/ID, and trains the BTB. Sits between the hazard unit, the instruction memory address port, and the ID-stage target-computation logic. No architectural delay slot: the wrong-path instruction in IF is flushed.

---
 rtl/fetch_redirect_if.sv | 31 +++
 rtl/fetch_redirect_unit.sv | 131 +++++++++++++
 tb/tb_fetch_redirect_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_if.sv
// Fetch-side bus: hazard stall, imem PC/prediction, ID-stage resolution, flush.
interface fetch_redirect_if;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        is_branch;
  logic        branched;
  logic        jumped;
  logic [31:0] pc_new;
  logic        flush;
  logic [15:0] redirect_cnt;

  // Fetch unit side
  modport slave (
    input  stall, id_valid, id_pc, id_pred_taken, id_pred_target,
           is_branch, branched, jumped, pc_new,
    output pc, pred_taken, pred_target, flush, redirect_cnt
  );

  // Pipeline / environment side
  modport master (
    output stall, id_valid, id_pc, id_pred_taken, id_pred_target,
           is_branch, branched, jumped, pc_new,
    input  pc, pred_taken, pred_target, flush, redirect_cnt
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner with a direct-mapped BTB (2-bit counters) and ID-stage
// misprediction recovery: redirect + same-cycle flush, BTB training.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned BTB_IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_redirect_if.slave  bus
);

  localparam int unsigned BTB_N  = 1 << BTB_IDX_W;
  localparam int unsigned TAG_LO = BTB_IDX_W + 2;
  localparam int unsigned TAG_W  = 32 - TAG_LO;
  localparam int unsigned IDX_HI = BTB_IDX_W + 1;

  logic [31:0]          pc_q, pc_d;
  logic [BTB_N-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [BTB_N];
  logic [TAG_W-1:0]     tag_d [BTB_N];
  logic [31:0]          tgt_q [BTB_N];
  logic [31:0]          tgt_d [BTB_N];
  logic [1:0]           ctr_q [BTB_N];
  logic [1:0]           ctr_d [BTB_N];
  logic [15:0]          cnt_q, cnt_d;

  logic [BTB_IDX_W-1:0] lk_idx, id_idx;
  logic [TAG_W-1:0]     lk_tag, id_tag;
  logic                 lk_hit, id_hit;
  logic                 pred_taken_c;
  logic [31:0]          pred_target_c;
  logic [31:0]          actual_next;
  logic                 mispredict;

  // Prediction for the current fetch PC is carried down the pipe but only
  // the predicted target matters for detecting a mispredict.
  logic unused_id_pred_taken;
  assign unused_id_pred_taken = bus.id_pred_taken;

  // BTB lookup on the fetch PC
  always_comb begin
    lk_idx        = pc_q[IDX_HI:2];
    lk_tag        = pc_q[31:TAG_LO];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_c  = lk_hit && ctr_q[lk_idx][1];
    pred_target_c = pred_taken_c ? tgt_q[lk_idx] : (pc_q + 32'd4);
  end

  // Resolve the ID instruction against what was predicted for it
  always_comb begin
    id_idx      = bus.id_pc[IDX_HI:2];
    id_tag      = bus.id_pc[31:TAG_LO];
    id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    actual_next = (bus.branched || bus.jumped) ? bus.pc_new : (bus.id_pc + 32'd4);
    mispredict  = bus.id_valid && (actual_next != bus.id_pred_target);
  end

  // Next PC: mispredict beats stall beats prediction
  always_comb begin
    pc_d = pred_target_c;
    if (mispredict) begin
      pc_d = actual_next;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  // Saturating mispredict counter
  always_comb begin
    cnt_d = cnt_q;
    if (mispredict && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // BTB training from resolved control-flow instructions
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (bus.id_valid && (bus.is_branch || bus.jumped)) begin
      if (id_hit) begin
        if (bus.jumped) begin
          tgt_d[id_idx] = bus.pc_new;
          ctr_d[id_idx] = 2'b11;
        end else if (bus.branched) begin
          tgt_d[id_idx] = bus.pc_new;
          if (ctr_q[id_idx] != 2'b11) ctr_d[id_idx] = ctr_q[id_idx] + 2'b01;
        end else begin
          if (ctr_q[id_idx] != 2'b00) ctr_d[id_idx] = ctr_q[id_idx] - 2'b01;
        end
      end else if (bus.branched || bus.jumped) begin
        valid_d[id_idx] = 1'b1;
        tag_d[id_idx]   = id_tag;
        tgt_d[id_idx]   = bus.pc_new;
        ctr_d[id_idx]   = bus.jumped ? 2'b11 : 2'b10;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < BTB_N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b00;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < BTB_N; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pred_taken   = pred_taken_c;
  assign bus.pred_target  = pred_target_c;
  assign bus.flush        = mispredict;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: cold/warm BTB, counter decay,
// stall vs mispredict, saturation, aliasing, PC wrap, async reset.
module tb_fetch_redirect_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_chk  = 0;

  fetch_redirect_if bus_if ();

  fetch_redirect_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [31:0] ipc, input logic [31:0] ptgt,
                        input logic isb, input logic br, input logic jmp,
                        input logic [31:0] pnew);
    bus_if.id_valid       = v;
    bus_if.id_pc          = ipc;
    bus_if.id_pred_target = ptgt;
    bus_if.id_pred_taken  = 1'b0;
    bus_if.is_branch      = isb;
    bus_if.branched       = br;
    bus_if.jumped         = jmp;
    bus_if.pc_new         = pnew;
  endtask

  task automatic idle();
    set_id(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // advance to the next falling edge (registers settled)
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // non-control mispredict used to steer the fetch PC to tgt
  task automatic steer(input logic [31:0] tgt);
    set_id(1'b1, tgt - 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    idle();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus_if.stall = 1'b0;
    idle();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pc", bus_if.pc, 32'h3000);
    chk("rst_pred_taken", 32'(bus_if.pred_taken), 32'h0);
    chk("rst_pred_target", bus_if.pred_target, 32'h3004);
    chk("rst_cnt", 32'(bus_if.redirect_cnt), 32'h0);
    chk("rst_flush", 32'(bus_if.flush), 32'h0);
    cyc();
    chk("seq_pc", bus_if.pc, 32'h3004);

    // cold taken BEQ
    set_id(1'b1, 32'h3010, 32'h3014, 1'b1, 1'b1, 1'b0, 32'h3040);
    #1 chk("cold_flush", 32'(bus_if.flush), 32'h1);
    cyc();
    idle();
    chk("cold_pc", bus_if.pc, 32'h3040);
    chk("cold_cnt", 32'(bus_if.redirect_cnt), 32'd1);
    steer(32'h3010);
    chk("steer_pc", bus_if.pc, 32'h3010);
    chk("cold_cnt2", 32'(bus_if.redirect_cnt), 32'd2);
    chk("warm_pred_taken", 32'(bus_if.pred_taken), 32'h1);
    chk("warm_pred_target", bus_if.pred_target, 32'h3040);
    cyc();
    chk("follow_pred_pc", bus_if.pc, 32'h3040);

    // warm BEQ predicted correctly
    set_id(1'b1, 32'h3010, 32'h3040, 1'b1, 1'b1, 1'b0, 32'h3040);
    #1 chk("warm_flush", 32'(bus_if.flush), 32'h0);
    cyc();
    idle();
    chk("warm_cnt", 32'(bus_if.redirect_cnt), 32'd2);
    chk("warm_seq_pc", bus_if.pc, 32'h3044);

    // counter decay 11 -> 10 -> 01
    for (int k = 0; k < 2; k++) begin
      set_id(1'b1, 32'h3010, 32'h3040, 1'b1, 1'b0, 1'b0, 32'h3040);
      #1 chk("decay_flush", 32'(bus_if.flush), 32'h1);
      cyc();
      idle();
      chk("decay_pc", bus_if.pc, 32'h3014);
      chk("decay_cnt", 32'(bus_if.redirect_cnt), 32'(3 + k));
    end
    steer(32'h3010);
    chk("decay_pred_taken", 32'(bus_if.pred_taken), 32'h0);
    chk("decay_pred_target", bus_if.pred_target, 32'h3014);

    // stall three cycles, J32 mispredict in the third
    bus_if.stall = 1'b1;
    cyc();
    chk("stall_pc1", bus_if.pc, 32'h3010);
    cyc();
    chk("stall_pc2", bus_if.pc, 32'h3010);
    set_id(1'b1, 32'h3020, 32'h3024, 1'b0, 1'b0, 1'b1, 32'h0000_3100);
    #1 chk("stall_jmp_flush", 32'(bus_if.flush), 32'h1);
    cyc();
    idle();
    bus_if.stall = 1'b0;
    chk("stall_jmp_pc", bus_if.pc, 32'h3100);
    chk("stall_jmp_cnt", 32'(bus_if.redirect_cnt), 32'd6);
    steer(32'h3020);
    chk("jmp_pred_taken", 32'(bus_if.pred_taken), 32'h1);
    chk("jmp_pred_target", bus_if.pred_target, 32'h3100);

    // tag alias at same index as 0x3010
    steer(32'h3030);
    chk("alias_pred_taken", 32'(bus_if.pred_taken), 32'h0);
    chk("alias_pred_target", bus_if.pred_target, 32'h3034);
    chk("alias_cnt", 32'(bus_if.redirect_cnt), 32'd8);

    // id_pc+4 wraps to 0: correct prediction of 0 is no mispredict
    set_id(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 chk("wrap_flush", 32'(bus_if.flush), 32'h0);
    cyc();
    idle();
    chk("wrap_cnt", 32'(bus_if.redirect_cnt), 32'd8);

    // drive counter to saturation
    set_id(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 65527; k++) cyc();
    chk("sat_cnt_max", 32'(bus_if.redirect_cnt), 32'hFFFF);
    cyc();
    cyc();
    chk("sat_cnt_hold", 32'(bus_if.redirect_cnt), 32'hFFFF);

    // async reset mid-operation with a mispredict pending
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus_if.pc, 32'h3000);
    chk("async_rst_cnt", 32'(bus_if.redirect_cnt), 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    steer(32'h3020);
    chk("post_rst_btb_cleared", 32'(bus_if.pred_taken), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
